// File: rtl/tlb_ctrl.sv
// ---------------------------------------------------------------------------
// tlb_ctrl -- TLB storage and management engine
//
// Owns the TLB entry array. Executes the CP0 TLB instructions TLBR, TLBWI,
// TLBWR and TLBP, and maintains the CP0 Random register. The whole array is
// driven out on `entries` so that the instruction-side and data-side
// tlb_lookup instances can translate in parallel.
//
// Ports
//   clk           in   clock
//   rst_n         in   synchronous reset, active-low
//   req_valid     in   TLB instruction request
//   req_ready     out  high only while idle; accepted on req_valid && req_ready
//   req_op        in   2'b00 TLBR, 2'b01 TLBWI, 2'b10 TLBWR, 2'b11 TLBP
//   req_index     in   CP0 Index (TLBR / TLBWI target)
//   req_entry     in   EntryHi/Lo0/Lo1 image; TLBP uses only vpn2/asid
//   cp0_wired     in   CP0 Wired
//   cp0_wired_we  in   Wired written this cycle
//   resp_valid    out  one-cycle completion pulse, no backpressure
//   resp_entry    out  entry read by TLBR; zero for the other ops
//   resp_index    out  TLBP hit index, or the index that was written
//   resp_miss     out  TLBP found no match (CP0 Index.P)
//   resp_mcheck   out  duplicate mapping detected on a write
//   random        out  CP0 Random
//   entries       out  the full entry array
//
// Build options
//   TLB_ENTRIES_NUM   default entry count (16 when not defined)
//   TLB_DUP_CHECK_EN  when defined, TLBWI/TLBWR compare the new entry against
//                     every other entry and raise resp_mcheck on a duplicate;
//                     when undefined resp_mcheck is tied low.
// ---------------------------------------------------------------------------

`ifndef TLB_ENTRIES_NUM
`define TLB_ENTRIES_NUM 16
`endif

package tlb_pkg;

    // One TLB entry: EntryHi (vpn2, asid), global bit and the even/odd
    // EntryLo halves.
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

endpackage

module tlb_ctrl
    import tlb_pkg::*;
#(
    parameter int  ENTRIES = `TLB_ENTRIES_NUM,
    localparam int IW      = $clog2(ENTRIES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_op,
    input  logic [IW-1:0]               req_index,
    input  tlb_entry_t                  req_entry,
    input  logic [IW-1:0]               cp0_wired,
    input  logic                        cp0_wired_we,
    output logic                        resp_valid,
    output tlb_entry_t                  resp_entry,
    output logic [IW-1:0]               resp_index,
    output logic                        resp_miss,
    output logic                        resp_mcheck,
    output logic [IW-1:0]               random,
    output tlb_entry_t [ENTRIES-1:0]    entries
);

    localparam logic [IW-1:0] LAST_IDX = IW'(ENTRIES - 1);

    typedef enum logic [1:0] {
        OP_TLBR  = 2'b00,
        OP_TLBWI = 2'b01,
        OP_TLBWR = 2'b10,
        OP_TLBP  = 2'b11
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE,
        ST_RESP
    } state_e;

    state_e                   state_q, state_d;
    tlb_entry_t [ENTRIES-1:0] entries_q, entries_d;
    logic [IW-1:0]            scan_idx_q, scan_idx_d;
    logic [18:0]              probe_vpn2_q, probe_vpn2_d;
    logic [7:0]               probe_asid_q, probe_asid_d;
    logic [IW-1:0]            random_q, random_d;
    tlb_entry_t               resp_entry_q, resp_entry_d;
    logic [IW-1:0]            resp_index_q, resp_index_d;
    logic                     resp_miss_q, resp_miss_d;
    logic                     resp_mcheck_q, resp_mcheck_d;

    tlb_op_e                  op;
    logic [IW-1:0]            write_idx;
    logic                     probe_hit;
    logic                     dup_hit;

    // Shared match rule for TLBP and the duplicate check. extra_g lets the
    // incoming entry's global bit widen the match for the duplicate check.
    function automatic logic entry_match(input tlb_entry_t  ent,
                                         input logic [18:0] vpn2,
                                         input logic [7:0]  asid,
                                         input logic        extra_g);
        return (ent.vpn2 == vpn2) && ((ent.asid == asid) || ent.g || extra_g);
    endfunction

    assign op        = tlb_op_e'(req_op);
    // TLBWR targets the Random value present at the accept edge, before
    // Random itself steps on that same edge.
    assign write_idx = (op == OP_TLBWR) ? random_q : req_index;
    assign probe_hit = entry_match(entries_q[scan_idx_q], probe_vpn2_q, probe_asid_q, 1'b0);

`ifdef TLB_DUP_CHECK_EN
    // Parallel compare of the incoming entry against every entry except the
    // one about to be overwritten.
    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if ((IW'(i) != write_idx) &&
                entry_match(entries_q[i], req_entry.vpn2, req_entry.asid, req_entry.g)) begin
                dup_hit = 1'b1;
            end
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    // Next-state logic: FSM transitions, entry writes, probe scan, response
    // capture and the free-running Random counter.
    always_comb begin
        state_d       = state_q;
        entries_d     = entries_q;
        scan_idx_d    = scan_idx_q;
        probe_vpn2_d  = probe_vpn2_q;
        probe_asid_d  = probe_asid_q;
        resp_entry_d  = resp_entry_q;
        resp_index_d  = resp_index_q;
        resp_miss_d   = resp_miss_q;
        resp_mcheck_d = resp_mcheck_q;

        if (cp0_wired_we || (random_q <= cp0_wired)) begin
            random_d = LAST_IDX;
        end else begin
            random_d = random_q - 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    unique case (op)
                        OP_TLBR: begin
                            resp_entry_d  = entries_q[req_index];
                            resp_index_d  = req_index;
                            resp_miss_d   = 1'b0;
                            resp_mcheck_d = 1'b0;
                            state_d       = ST_RESP;
                        end
                        OP_TLBWI, OP_TLBWR: begin
                            entries_d[write_idx] = req_entry;
                            resp_entry_d  = '0;
                            resp_index_d  = write_idx;
                            resp_miss_d   = 1'b0;
                            resp_mcheck_d = dup_hit;
                            state_d       = ST_RESP;
                        end
                        OP_TLBP: begin
                            probe_vpn2_d = req_entry.vpn2;
                            probe_asid_d = req_entry.asid;
                            scan_idx_d   = '0;
                            state_d      = ST_PROBE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_PROBE: begin
                // Response registers are only updated on the way into RESP so
                // they keep their previous values while the scan runs.
                if (probe_hit) begin
                    resp_entry_d  = '0;
                    resp_index_d  = scan_idx_q;
                    resp_miss_d   = 1'b0;
                    resp_mcheck_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (scan_idx_q == LAST_IDX) begin
                    resp_entry_d  = '0;
                    resp_index_d  = '0;
                    resp_miss_d   = 1'b1;
                    resp_mcheck_d = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset; reset aborts any
    // operation in flight and clears the whole array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            entries_q     <= '0;
            scan_idx_q    <= '0;
            probe_vpn2_q  <= '0;
            probe_asid_q  <= '0;
            random_q      <= LAST_IDX;
            resp_entry_q  <= '0;
            resp_index_q  <= '0;
            resp_miss_q   <= 1'b0;
            resp_mcheck_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            entries_q     <= entries_d;
            scan_idx_q    <= scan_idx_d;
            probe_vpn2_q  <= probe_vpn2_d;
            probe_asid_q  <= probe_asid_d;
            random_q      <= random_d;
            resp_entry_q  <= resp_entry_d;
            resp_index_q  <= resp_index_d;
            resp_miss_q   <= resp_miss_d;
            resp_mcheck_q <= resp_mcheck_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = (state_q == ST_RESP);
    assign resp_entry  = resp_entry_q;
    assign resp_index  = resp_index_q;
    assign resp_miss   = resp_miss_q;
    assign resp_mcheck = resp_mcheck_q;
    assign random      = random_q;
    assign entries     = entries_q;

endmodule

// File: tb/tb_tlb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tlb_ctrl -- scoreboard testbench for tlb_ctrl (16 entries)
//
// Directed requests push their hand-derived response (including the cycle
// it must appear in) into a queue; an independent monitor pops and compares
// on every resp_valid pulse. Direct checks cover reset state, Random
// sequencing and entry visibility. Honours TLB_DUP_CHECK_EN for the
// expected resp_mcheck values.
// ---------------------------------------------------------------------------

module tb_tlb_ctrl;
    import tlb_pkg::*;

    localparam int IW = 4;
    localparam int ENTRIES = 16;

    localparam logic [1:0] OP_TLBR  = 2'b00;
    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b10;
    localparam logic [1:0] OP_TLBP  = 2'b11;

`ifdef TLB_DUP_CHECK_EN
    localparam logic DUP_EN = 1'b1;
`else
    localparam logic DUP_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     req_valid;
    logic                     req_ready;
    logic [1:0]               req_op;
    logic [IW-1:0]            req_index;
    tlb_entry_t               req_entry;
    logic [IW-1:0]            cp0_wired;
    logic                     cp0_wired_we;
    logic                     resp_valid;
    tlb_entry_t               resp_entry;
    logic [IW-1:0]            resp_index;
    logic                     resp_miss;
    logic                     resp_mcheck;
    logic [IW-1:0]            random;
    tlb_entry_t [ENTRIES-1:0] entries;

    tlb_ctrl #(.ENTRIES(ENTRIES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_index    (req_index),
        .req_entry    (req_entry),
        .cp0_wired    (cp0_wired),
        .cp0_wired_we (cp0_wired_we),
        .resp_valid   (resp_valid),
        .resp_entry   (resp_entry),
        .resp_index   (resp_index),
        .resp_miss    (resp_miss),
        .resp_mcheck  (resp_mcheck),
        .random       (random),
        .entries      (entries)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Cycle counter used to timestamp expected responses.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        tlb_entry_t    entry;
        logic [IW-1:0] index;
        logic          miss;
        logic          mcheck;
        bit            chk_idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    tlb_entry_t e1, e3, e9, e15, e7, e6, pe;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic tlb_entry_t make_entry(input logic [18:0] vpn2, input logic [7:0] asid,
                                              input logic g, input logic [19:0] pfn0,
                                              input logic [19:0] pfn1);
        tlb_entry_t t;
        t = '0;
        t.vpn2 = vpn2;
        t.asid = asid;
        t.g    = g;
        t.pfn0 = pfn0;
        t.c0   = 3'd3;
        t.d0   = 1'b1;
        t.v0   = 1'b1;
        t.pfn1 = pfn1;
        t.c1   = 3'd2;
        t.d1   = 1'b0;
        t.v1   = 1'b1;
        return t;
    endfunction

    function automatic exp_t make_exp(input tlb_entry_t ent, input logic [IW-1:0] idx,
                                      input logic miss, input logic mc, input bit chk_idx);
        exp_t e;
        e.cyc     = 0;
        e.entry   = ent;
        e.index   = idx;
        e.miss    = miss;
        e.mcheck  = mc;
        e.chk_idx = chk_idx;
        return e;
    endfunction

    function automatic tlb_entry_t probe_key(input logic [18:0] vpn2, input logic [7:0] asid);
        tlb_entry_t t;
        t = '0;
        t.vpn2 = vpn2;
        t.asid = asid;
        return t;
    endfunction

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("resp_cycle",  128'(cyc),          128'(mon_e.cyc));
                checkOutput("resp_entry",  128'(resp_entry),   128'(mon_e.entry));
                checkOutput("resp_miss",   128'(resp_miss),    128'(mon_e.miss));
                checkOutput("resp_mcheck", 128'(resp_mcheck),  128'(mon_e.mcheck));
                if (mon_e.chk_idx) begin
                    checkOutput("resp_index", 128'(resp_index), 128'(mon_e.index));
                end
            end
        end
    end

    // Issue one request from a negedge; optionally push its expected response
    // due lat cycles after the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [IW-1:0] idx,
                                 input tlb_entry_t ent, input bit push, input exp_t e,
                                 input int lat);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_ready_timeout: got req_ready=0 expected 1");
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_index = idx;
        req_entry = ent;
        if (push) begin
            e.cyc = cyc + lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL resp_timeout: got no resp_valid expected one at cycle %0d", mon_e.cyc);
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int pulses;
        int exp_r;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_op       = OP_TLBR;
        req_index    = '0;
        req_entry    = '0;
        cp0_wired    = '0;
        cp0_wired_we = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_random",     128'(random),      128'(15));
        checkOutput("reset_req_ready",  128'(req_ready),   128'(1));
        checkOutput("reset_resp_valid", 128'(resp_valid),  128'(0));
        checkOutput("reset_resp_index", 128'(resp_index),  128'(0));
        checkOutput("reset_resp_miss",  128'(resp_miss),   128'(0));
        for (int i = 0; i < ENTRIES; i++) begin
            checkOutput("reset_entry", 128'(entries[i]), 128'(0));
        end
        rst_n = 1'b1;

        e1  = make_entry(19'h12345, 8'h07, 1'b0, 20'hABCDE, 20'h13579);
        e3  = make_entry(19'h00ABC, 8'h01, 1'b0, 20'h00333, 20'h00334);
        e9  = make_entry(19'h00ABC, 8'h05, 1'b1, 20'h00999, 20'h0099A);
        e15 = make_entry(19'h55555, 8'h03, 1'b0, 20'h0F0F0, 20'h0F0F1);
        e7  = make_entry(19'h3FFFF, 8'h10, 1'b0, 20'h77777, 20'h77778);
        e6  = make_entry(19'h00ABC, 8'h01, 1'b0, 20'h00666, 20'h00667);

        applyStimulus(OP_TLBWI, 4'd5, e1, 1'b1, make_exp('0, 4'd5, 1'b0, 1'b0, 1'b1), 1);
        checkOutput("tlbwi_visible_5", 128'(entries[5]), 128'(e1));
        applyStimulus(OP_TLBR, 4'd5, '0, 1'b1, make_exp(e1, 4'd5, 1'b0, 1'b0, 1'b0), 1);

        applyStimulus(OP_TLBWI, 4'd3, e3, 1'b1, make_exp('0, 4'd3, 1'b0, 1'b0, 1'b1), 1);
        applyStimulus(OP_TLBWI, 4'd9, e9, 1'b1, make_exp('0, 4'd9, 1'b0, DUP_EN, 1'b1), 1);

        pe = probe_key(19'h00ABC, 8'h02);
        applyStimulus(OP_TLBP, 4'd0, pe, 1'b1, make_exp('0, 4'd9, 1'b0, 1'b0, 1'b1), 11);
        pe = probe_key(19'h00ABC, 8'h01);
        applyStimulus(OP_TLBP, 4'd0, pe, 1'b1, make_exp('0, 4'd3, 1'b0, 1'b0, 1'b1), 5);
        pe = probe_key(19'h07777, 8'h00);
        applyStimulus(OP_TLBP, 4'd0, pe, 1'b1, make_exp('0, 4'd0, 1'b1, 1'b0, 1'b1), 17);
        pe = probe_key(19'h00000, 8'h00);
        applyStimulus(OP_TLBP, 4'd0, pe, 1'b1, make_exp('0, 4'd0, 1'b0, 1'b0, 1'b1), 2);

        applyStimulus(OP_TLBWI, 4'd15, e15, 1'b1, make_exp('0, 4'd15, 1'b0, 1'b0, 1'b1), 1);
        pe = probe_key(19'h55555, 8'h03);
        applyStimulus(OP_TLBP, 4'd0, pe, 1'b1, make_exp('0, 4'd15, 1'b0, 1'b0, 1'b1), 17);
        waitDrain();

        // Random: Wired=4 written, then 15 down to 4 and back to 15.
        @(negedge clk);
        cp0_wired    = 4'd4;
        cp0_wired_we = 1'b1;
        @(negedge clk);
        cp0_wired_we = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k <= 11)      exp_r = 15 - k;
            else if (k == 12) exp_r = 15;
            else              exp_r = 14;
            checkOutput("random_seq", 128'(random), 128'(exp_r));
            if (k == 8) begin
                req_valid = 1'b1;
                req_op    = OP_TLBWR;
                req_index = 4'd2;
                req_entry = e7;
                mon_e     = make_exp('0, 4'd7, 1'b0, 1'b0, 1'b1);
                mon_e.cyc = cyc + 1;
                exp_q.push_back(mon_e);
            end
            if (k == 9) begin
                req_valid = 1'b0;
                checkOutput("tlbwr_visible_7", 128'(entries[7]), 128'(e7));
                checkOutput("tlbwr_decoy_2",   128'(entries[2]), 128'(0));
            end
            @(negedge clk);
        end

        applyStimulus(OP_TLBR, 4'd7, '0, 1'b1, make_exp(e7, 4'd7, 1'b0, 1'b0, 1'b0), 1);
        applyStimulus(OP_TLBWI, 4'd5, e1, 1'b1, make_exp('0, 4'd5, 1'b0, 1'b0, 1'b1), 1);
        applyStimulus(OP_TLBWI, 4'd6, e6, 1'b1, make_exp('0, 4'd6, 1'b0, DUP_EN, 1'b1), 1);
        waitDrain();

        // Reset in the middle of a probe must abort it silently.
        pe = probe_key(19'h07777, 8'h00);
        applyStimulus(OP_TLBP, 4'd0, pe, 1'b0, make_exp('0, 4'd0, 1'b0, 1'b0, 1'b0), 0);
        repeat (3) @(negedge clk);
        checkOutput("probe_busy_ready", 128'(req_ready), 128'(0));
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready",    128'(req_ready),  128'(1));
        checkOutput("abort_random",   128'(random),     128'(15));
        checkOutput("abort_entry5",   128'(entries[5]), 128'(0));
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        checkOutput("abort_no_resp", 128'(pulses), 128'(0));

        waitDrain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
